// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default bit timing and data width.
// Used by the transmitter now and by the receiver once it migrates.
package uart_pkg;

  localparam logic [2:0] UART_ST_IDLE   = 3'd0;
  localparam logic [2:0] UART_ST_START  = 3'd1;
  localparam logic [2:0] UART_ST_DATA   = 3'd2;
  localparam logic [2:0] UART_ST_STOP   = 3'd3;
  localparam logic [2:0] UART_ST_PARITY = 3'd4;

  localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 1250;
  localparam int unsigned UART_DATA_BITS            = 8;

  typedef enum logic [2:0] {
    IDLE   = UART_ST_IDLE,
    START  = UART_ST_START,
    DATA   = UART_ST_DATA,
    STOP   = UART_ST_STOP,
    PARITY = UART_ST_PARITY
  } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter with synchronous clear; bit_end_o pulses
// for one cycle on the last clock of every CLKS_PER_BIT-long bit period.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 1250
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic bit_end_o
);

  localparam logic [15:0] LAST_COUNT = 16'(CLKS_PER_BIT - 1);

  logic [15:0] count_q, count_d;

  assign bit_end_o = (count_q == LAST_COUNT);

  always_comb begin
    count_d = count_q + 16'd1;
    if (clear_i || bit_end_o) begin
      count_d = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, stop bit, with a
// start/busy/done handshake. Define UART_TX_PARITY_EN to insert a parity bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = UART_DATA_BITS
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       Rs232_tx
);

  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  uart_state_e state_q, state_d;
  logic [2:0]  idx_q, idx_d, idx_inc;
  logic [7:0]  shift_q, shift_d;
  logic        line_q, line_d;
  logic        done_q, done_d;
  logic        bit_end;
  logic        timer_clear;

  // Holding the timer cleared while idle makes the start bit begin a fresh period.
  assign timer_clear = (state_q == IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (timer_clear),
    .bit_end_o(bit_end)
  );

`ifdef UART_TX_PARITY_EN
  logic parity_bit;
  assign parity_bit = (^shift_q) ^ PARITY_ODD;
`endif

  assign idx_inc  = idx_q + 3'd1;
  assign tx_busy  = (state_q != IDLE);
  assign tx_done  = done_q;
  assign Rs232_tx = line_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    line_d  = line_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        line_d = 1'b1;
        if (tx_start) begin
          shift_d = tx_data;
          idx_d   = 3'd0;
          line_d  = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          idx_d   = 3'd0;
          line_d  = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            line_d  = parity_bit;
            state_d = PARITY;
`else
            line_d  = 1'b1;
            state_d = STOP;
`endif
          end else begin
            idx_d  = idx_inc;
            line_d = shift_q[idx_inc];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          line_d  = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          line_d  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        line_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      line_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      line_q  <= line_d;
      done_q  <= done_d;
    end
  end

  // The captured byte needs no reset; it is always loaded before being used.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule
